weight_dump: RTL and testbench
==============================

# weight_dump

Host-facing transmitter that streams the network's trained weights and the latest output-neuron result off-chip, one byte at a time, over a four-phase valid/ack handshake. It sits beside the training state machine: the weight registers of both hidden neurons and the output neuron are written during backprop; this block reads them and serializes them for an external reader. On a start request it snapshots the weights and result, then emits a 15-byte framed packet with header and checksum. Training continues undisturbed.

## Interface
Parameters:
- HDR_BYTE, 8'hA5, frame header byte
- SYNC_STAGES, 2, flip-flop stages on ack_i (min 2)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  dump request, synchronous to clk_i, rising edge acted on
- hn0_weights_i  in  32  hidden neuron 0 weights {w3,w2,w1,w0}
- hn1_weights_i  in  32  hidden neuron 1 weights {w3,w2,w1,w0}
- on_weights_i  in  16  output neuron weights {w1,w0}
- final_i  in  19  output neuron result
- ack_i  in  1  host acknowledge, asynchronous to clk_i
- data_o  out  8  current frame byte
- valid_o  out  1  data_o valid, four-phase handshake
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse after last byte's handshake completes
- byte_idx_o  out  4  index of byte on data_o, 0..14

## Operation
- One clock; reset is asynchronous and active-low (clk_i, rst_i).
- Frame order (idx: content): 0 HDR_BYTE; 1-4 hn0 bytes [7:0]..[31:24]; 5-8 hn1 bytes LSB first; 9-10 on_weights LSB first; 11 final[7:0]; 12 final[15:8]; 13 {5'b0, final[18:16]}; 14 checksum = XOR of bytes 0-13.
- Checksum accumulated byte-by-byte as bytes are presented; 8-bit, no carry.
- States: IDLE -> LOAD -> PRESENT <-> RELEASE -> DONE -> IDLE.
  - IDLE: busy_o=0. Rising edge of start_i: capture all inputs into 14-byte snapshot, clear checksum, idx=0, go LOAD.
  - LOAD: wait until synchronized ack low, then go PRESENT.
  - PRESENT: valid_o=1, data_o=byte[idx]. On synchronized ack high: drop valid_o, go RELEASE.
  - RELEASE: valid_o=0, data_o held. On synchronized ack low: if idx=14 go DONE, else idx+1, go PRESENT.
  - DONE: done_o=1 for one cycle, go IDLE.
- Snapshot is immutable for the whole frame; input changes mid-frame never appear in output.
- start_i edges while busy_o=1 ignored (not queued).
- ack_i activity in IDLE ignored.
- Reset mid-frame: frame abandoned, all outputs to reset values immediately; no partial done_o.

## Timing
- Reset values: data_o=0, valid_o=0, busy_o=0, done_o=0, byte_idx_o=0, state IDLE.
- start_i rising edge sampled at edge N: busy_o=1 after N; with ack low, valid_o=1 and data_o=HDR_BYTE after edge N+1.
- ack_i to internal ack: SYNC_STAGES clocks; valid_o falls one clock after synchronized ack high; next byte valid one clock after synchronized ack low.
- data_o and byte_idx_o change only on PRESENT entry; stable through RELEASE.
- Per byte minimum: 2*(SYNC_STAGES+1) clocks with an immediately responding host.
- done_o asserted the cycle after final RELEASE exit; busy_o falls with done_o deassertion.

## Structure
- Package weight_dump_pkg: state enum, FRAME_BYTES=15, LAST_IDX=4'd14, default HDR_BYTE.
- Sub-module sync_ff (parameter STAGES) for ack_i; reusable for other pin inputs.
- Snapshot as byte array indexed by idx; checksum register separate.

## Test plan
- Basic frame: hn0=hn1=32'h04030201, on=16'h0201, final=0, host acks promptly -> bytes A5,01,02,03,04,01,02,03,04,01,02,00,00,00,A6; done_o one pulse; busy_o low after.
- Final width: final=19'h7ABCD -> bytes 11-13 = CD,AB,07; checksum matches XOR.
- Snapshot hold: change all weight inputs after byte 2 presented -> remaining bytes reflect captured values.
- Ack already high at start -> valid_o stays 0 until ack low, then header presented; start_i pulse during frame -> no restart, byte sequence unchanged.
- Slow host: hold ack high 20 clocks per byte -> valid_o stays low, data_o stable, no byte skipped or repeated.
- Reset asserted at byte 7 -> all outputs 0 asynchronously; new start after release yields complete frame from byte 0.

Source files
------------

// File: rtl/weight_dump_pkg.sv
// rtl/weight_dump_pkg.sv - shared types and constants for the weight dump transmitter
//
// Contents:
//   state_t      transmit FSM states
//   FRAME_BYTES  bytes per frame (header, 13 payload bytes, checksum)
//   SNAP_BYTES   bytes held in the snapshot (everything except the checksum)
//   IDX_W        width of the byte index
//   LAST_IDX     index of the checksum byte
//   DEFAULT_HDR  default frame header byte
package weight_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam int             FRAME_BYTES = 15;
    localparam int             SNAP_BYTES  = FRAME_BYTES - 1;
    localparam int             IDX_W       = 4;
    localparam logic [IDX_W-1:0] LAST_IDX  = 4'd14;
    localparam logic [7:0]     DEFAULT_HDR = 8'hA5;

endpackage

// File: rtl/weight_dump_if.sv
// rtl/weight_dump_if.sv - byte-wide four-phase valid/ack link to the off-chip reader
//
// Signals:
//   data_o      current frame byte (transmitter -> host)
//   valid_o     data_o valid (transmitter -> host)
//   byte_idx_o  index of the byte on data_o, 0..14 (transmitter -> host)
//   ack_i       host acknowledge, asynchronous to the transmitter clock (host -> transmitter)
// Modports:
//   master      transmitter side
//   slave       host side
interface weight_dump_if;
    import weight_dump_pkg::*;

    logic [7:0]       data_o;
    logic             valid_o;
    logic [IDX_W-1:0] byte_idx_o;
    logic             ack_i;

    modport master (
        output data_o,
        output valid_o,
        output byte_idx_o,
        input  ack_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  byte_idx_o,
        output ack_i
    );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchronizer for a single asynchronous pin
//
// Parameters:
//   STAGES  number of flip-flops in the chain (2 or more)
// Ports:
//   clk_i   destination clock
//   rst_i   asynchronous active-low reset, chain clears to 0
//   d_i     asynchronous input
//   q_o     synchronized output, STAGES clocks behind d_i
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/weight_dump.sv
// rtl/weight_dump.sv - snapshots trained weights and result, streams a 15-byte framed packet
//
// Parameters:
//   HDR_BYTE     frame header byte
//   SYNC_STAGES  synchronizer depth on the host ack (2 or more)
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-low reset
//   start_i        dump request, rising edge acted on while idle
//   hn0_weights_i  hidden neuron 0 weights {w3,w2,w1,w0}
//   hn1_weights_i  hidden neuron 1 weights {w3,w2,w1,w0}
//   on_weights_i   output neuron weights {w1,w0}
//   final_i        output neuron result
//   busy_o         frame in progress
//   done_o         one-cycle pulse after the checksum byte's handshake completes
//   host           byte link to the reader (data_o, valid_o, byte_idx_o, ack_i)
module weight_dump
    import weight_dump_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = DEFAULT_HDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   hn0_weights_i,
    input  logic [31:0]   hn1_weights_i,
    input  logic [15:0]   on_weights_i,
    input  logic [18:0]   final_i,
    output logic          busy_o,
    output logic          done_o,
    weight_dump_if.master host
);

    state_t           state_q;
    state_t           state_d;

    logic             start_q;
    logic             start_rise;
    logic             ack_sync;

    logic [7:0]       snap_q [SNAP_BYTES];
    logic [7:0]       csum_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       data_q;
    logic [IDX_W-1:0] byte_idx_q;

    logic             capture;
    logic             present_en;
    logic [IDX_W-1:0] present_idx;
    logic [7:0]       present_byte;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (host.ack_i),
        .q_o   (ack_sync)
    );

    assign start_rise = start_i & ~start_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // present_en marks every entry into PRESENT; it is the only moment the
    // output byte, the visible index and the running checksum move.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        present_en  = 1'b0;
        present_idx = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A host still holding ack from before must let go first,
                // otherwise the header would be acknowledged instantly.
                if (!ack_sync) begin
                    present_en  = 1'b1;
                    present_idx = '0;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ack_sync) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        present_en  = 1'b1;
                        present_idx = idx_q + 4'd1;
                        state_d     = ST_PRESENT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The checksum byte is whatever has been folded in by the time index 14
    // is presented, i.e. the XOR of bytes 0..13.
    always_comb begin
        if (present_idx == LAST_IDX) begin
            present_byte = csum_q;
        end else begin
            present_byte = snap_q[present_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            start_q    <= 1'b0;
            idx_q      <= '0;
            csum_q     <= '0;
            data_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            start_q <= start_i;
            if (capture) begin
                idx_q  <= '0;
                csum_q <= '0;
            end
            if (present_en) begin
                idx_q      <= present_idx;
                data_q     <= present_byte;
                byte_idx_q <= present_idx;
                if (present_idx != LAST_IDX) begin
                    csum_q <= csum_q ^ present_byte;
                end
            end
        end
    end

    // Snapshot is pure datapath: it is only ever read after a capture, so it
    // needs no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            snap_q[0]  <= HDR_BYTE;
            snap_q[1]  <= hn0_weights_i[7:0];
            snap_q[2]  <= hn0_weights_i[15:8];
            snap_q[3]  <= hn0_weights_i[23:16];
            snap_q[4]  <= hn0_weights_i[31:24];
            snap_q[5]  <= hn1_weights_i[7:0];
            snap_q[6]  <= hn1_weights_i[15:8];
            snap_q[7]  <= hn1_weights_i[23:16];
            snap_q[8]  <= hn1_weights_i[31:24];
            snap_q[9]  <= on_weights_i[7:0];
            snap_q[10] <= on_weights_i[15:8];
            snap_q[11] <= final_i[7:0];
            snap_q[12] <= final_i[15:8];
            snap_q[13] <= {5'b0, final_i[18:16]};
        end
    end

    assign host.valid_o    = (state_q == ST_PRESENT);
    assign host.data_o     = data_q;
    assign host.byte_idx_o = byte_idx_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_dump.sv
// tb/tb_weight_dump.sv - scoreboard bench for the weight dump transmitter
module tb_weight_dump;
    import weight_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] hn0 = '0;
    logic [31:0] hn1 = '0;
    logic [15:0] on_w = '0;
    logic [18:0] fin = '0;
    logic        busy;
    logic        done;
    logic        host_ack = 1'b0;
    logic        force_ack = 1'b0;

    weight_dump_if bus ();
    assign bus.ack_i = host_ack | force_ack;

    weight_dump #(
        .HDR_BYTE    (8'hA5),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .hn0_weights_i (hn0),
        .hn1_weights_i (hn1),
        .on_weights_i  (on_w),
        .final_i       (fin),
        .busy_o        (busy),
        .done_o        (done),
        .host          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   seen_cnt = 0;
    int   done_cnt = 0;
    int   ack_hold = 0;
    bit   abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] i);
        sbq.push_back(exp_t'({d, i}));
    endtask

    // Independent frame builder used for vectors not written out by hand.
    task automatic push_model(input logic [31:0] h0, input logic [31:0] h1,
                              input logic [15:0] ow, input logic [18:0] fr);
        logic [7:0] b [14];
        logic [7:0] c;
        b[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            b[1 + k] = h0[8*k +: 8];
            b[5 + k] = h1[8*k +: 8];
        end
        b[9]  = ow[7:0];
        b[10] = ow[15:8];
        b[11] = fr[7:0];
        b[12] = fr[15:8];
        b[13] = {5'b0, fr[18:16]};
        c = 8'h00;
        for (int k = 0; k < 14; k++) begin
            c = c ^ b[k];
            push_exp(b[k], 4'(k));
        end
        push_exp(c, 4'd14);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_seen(input int target);
        int k = 0;
        while (seen_cnt < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("wait_byte_timeout", 32'(seen_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int done_before);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt), 32'(done_before + 1));
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // Host model and monitor: pops one expected byte per PRESENT, acks,
    // and optionally sits on ack to emulate a slow reader.
    initial begin : host_proc
        exp_t       e;
        logic [7:0] got;
        int         k;
        forever begin
            @(negedge clk);
            if (bus.valid_o && !host_ack) begin
                if (sbq.size() == 0) begin
                    check("unexpected_byte", {24'd0, bus.data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("byte_data", {24'd0, bus.data_o}, {24'd0, e.d});
                    check("byte_idx", {28'd0, bus.byte_idx_o}, {28'd0, e.i});
                end
                seen_cnt++;
                got = bus.data_o;
                host_ack = 1'b1;
                k = 0;
                while (bus.valid_o && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (bus.valid_o) check("valid_drop_timeout", 32'(bus.valid_o), 32'd0);
                repeat (ack_hold) @(negedge clk);
                if (ack_hold > 0 && !abort) begin
                    check("slow_valid_low", 32'(bus.valid_o), 32'd0);
                    check("slow_data_stable", {24'd0, bus.data_o}, {24'd0, got});
                end
                host_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] basic_exp [15] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03,
                                   8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'hA6};
    logic [7:0] width_exp [15] = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34,
                                   8'h12, 8'hFE, 8'hCA, 8'hCD, 8'hAB, 8'h07, 8'hDA};

    initial begin : stim
        int d0;
        int base;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, bus.data_o}, 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", {28'd0, bus.byte_idx_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with start latency
        hn0 = 32'h04030201; hn1 = 32'h04030201; on_w = 16'h0201; fin = 19'h0;
        for (int i = 0; i < 15; i++) push_exp(basic_exp[i], 4'(i));
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid_early", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(bus.valid_o), 32'd1);
        check("lat_hdr", {24'd0, bus.data_o}, 32'hA5);
        wait_done(d0);

        // Full 19-bit result
        hn0 = 32'hDEADBEEF; hn1 = 32'h12345678; on_w = 16'hCAFE; fin = 19'h7ABCD;
        for (int i = 0; i < 15; i++) push_exp(width_exp[i], 4'(i));
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);

        // Snapshot must not follow input changes mid-frame
        hn0 = 32'h11223344; hn1 = 32'h55667788; on_w = 16'h99AA; fin = 19'h12345;
        push_model(hn0, hn1, on_w, fin);
        d0 = done_cnt;
        base = seen_cnt;
        pulse_start();
        wait_seen(base + 3);
        hn0 = 32'hFFFF_FFFF; hn1 = 32'h0; on_w = 16'h5A5A; fin = 19'h7FFFF;
        wait_done(d0);

        // Ack already high at start, plus a start pulse mid-frame
        hn0 = 32'hA1B2C3D4; hn1 = 32'h0F1E2D3C; on_w = 16'h8001; fin = 19'h40080;
        push_model(hn0, hn1, on_w, fin);
        d0 = done_cnt;
        base = seen_cnt;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (6) @(negedge clk);
        check("ackhigh_valid", 32'(bus.valid_o), 32'd0);
        check("ackhigh_busy", 32'(busy), 32'd1);
        force_ack = 1'b0;
        wait_seen(base + 5);
        pulse_start();
        wait_done(d0);
        repeat (10) @(negedge clk);
        check("no_queued_restart", 32'(busy), 32'd0);

        // Slow host
        hn0 = 32'h13579BDF; hn1 = 32'h2468ACE0; on_w = 16'h7E81; fin = 19'h3C3C3;
        push_model(hn0, hn1, on_w, fin);
        d0 = done_cnt;
        ack_hold = 20;
        pulse_start();
        wait_done(d0);
        ack_hold = 0;

        // Reset at byte 7, then a clean frame
        hn0 = 32'hCAFEBABE; hn1 = 32'h0BADF00D; on_w = 16'h1234; fin = 19'h55555;
        push_model(hn0, hn1, on_w, fin);
        d0 = done_cnt;
        base = seen_cnt;
        pulse_start();
        wait_seen(base + 8);
        abort = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", {24'd0, bus.data_o}, 32'd0);
        check("arst_valid", 32'(bus.valid_o), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_idx", {28'd0, bus.byte_idx_o}, 32'd0);
        sbq.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (host_ack && k < 200) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check("no_partial_done", 32'(done_cnt), 32'(d0));
        push_model(hn0, hn1, on_w, fin);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
